// File: rtl/trig_pkg.sv
// trig_pkg: shared types and table generation for the sine/cosine lookup unit.
//   quad_e      - quadrant of the folded angle (Q0..Q3)
//   mode_e      - per-sample function select (MODE_COS, MODE_SIN)
//   addr_width  - quarter-table address width for a given angle width
//   quarter_cos - quarter-wave table entry k, evaluated at elaboration time
package trig_pkg;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_e;
  typedef enum logic {MODE_COS = 1'b0, MODE_SIN = 1'b1} mode_e;

  localparam real C_HALF_PI = 1.5707963267948966;

  // The table holds 2^Q+1 entries (both end points), so it needs one bit more than Q.
  function automatic int addr_width(input int angle_w);
    return angle_w - 2 + 1;
  endfunction

  // round_half_away(2^(out_w-2) * cos(pi/2 * k / 2^q)).
  // Only ever called with constant arguments, so it folds to a constant per entry.
  // Every value is non-negative, so adding 0.5 and truncating rounds half away.
  // The end points are pinned so they are exact.
  function automatic int quarter_cos(input int k, input int q, input int out_w);
    real x;
    real x2;
    real term;
    real sum;
    if (k == 0) return 1 << (out_w - 2);
    if (k >= (1 << q)) return 0;
    x    = C_HALF_PI * real'(k) / real'(1 << q);
    x2   = x * x;
    term = 1.0;
    sum  = 1.0;
    // The Taylor series converges well past double precision for x <= pi/2 by n = 12.
    for (int n = 1; n <= 12; n++) begin
      term = -term * x2 / real'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    return $rtoi(sum * real'(1 << (out_w - 2)) + 0.5);
  endfunction

endpackage

// File: rtl/trig_quarter_rom.sv
// trig_quarter_rom: synchronous single-port quarter-wave cosine ROM.
//   Clk  - rising-edge clock
//   en   - read enable; data holds its previous value while en = 0
//   addr - table index 0..2^Q (Q = ANGLE_W-2)
//   data - unsigned table entry, 1.0 = 2^(OUT_W-2)
// data has no reset. It is only consumed when the matching stage valid is set.
module trig_quarter_rom
  import trig_pkg::*;
#(
  parameter int ANGLE_W = 10,
  parameter int OUT_W   = 16
) (
  input  logic                           Clk,
  input  logic                           en,
  input  logic [addr_width(ANGLE_W)-1:0] addr,
  output logic [OUT_W-1:0]               data
);

  localparam int Q     = ANGLE_W - 2;
  localparam int DEPTH = (1 << Q) + 1;

  logic [OUT_W-1:0] w_table [DEPTH];
  logic [OUT_W-1:0] r_data;

  for (genvar k = 0; k < DEPTH; k++) begin : g_lut
    localparam int C_VAL = quarter_cos(k, Q, OUT_W);
    assign w_table[k] = OUT_W'(C_VAL);
  end

  always_ff @(posedge Clk) begin
    if (en) r_data <= w_table[addr];
  end

  assign data = r_data;

endmodule

// File: rtl/trig_lut_pipe.sv
// trig_lut_pipe: 3-stage pipelined sin/cos lookup with valid/ready backpressure.
//   Clk, Reset_n          - rising-edge clock, async active-low reset
//   in_valid/in_ready     - input handshake; in_ready is the global stage enable
//   in_angle              - unsigned turns, 2^ANGLE_W = full turn
//   in_sin                - 0 = cos, 1 = sin
//   in_tag                - sideband, returned with the result
//   out_valid/out_ready   - output handshake
//   out_data              - signed Q2.(OUT_W-2) result
//   out_tag               - tag of out_data
// S1 folds the angle into the quarter table, S2 reads the ROM, S3 applies sign.
module trig_lut_pipe
  import trig_pkg::*;
#(
  parameter int ANGLE_W = 10,
  parameter int OUT_W   = 16,
  parameter int TAG_W   = 4
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ANGLE_W-1:0] in_angle,
  input  logic               in_sin,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int Q  = ANGLE_W - 2;
  localparam int AW = addr_width(ANGLE_W);

  localparam logic [ANGLE_W-1:0] C_QUARTER  = ANGLE_W'(1 << Q);
  localparam logic [AW-1:0]      C_ADDR_TOP = AW'(1 << Q);

  logic               w_en;
  logic [ANGLE_W-1:0] w_angle;
  quad_e              w_quad;
  logic [Q-1:0]       w_idx;
  logic [AW-1:0]      w_addr;
  logic               w_neg;
  logic [OUT_W-1:0]   w_rom;

  logic               r_v1, r_v2, r_v3;
  logic [AW-1:0]      r_addr1;
  logic               r_neg1, r_neg2;
  logic [TAG_W-1:0]   r_tag1, r_tag2, r_tag3;
  logic [OUT_W-1:0]   r_data3;

  // The whole pipe freezes only when a result is waiting on the consumer.
  assign w_en     = !(r_v3 && !out_ready);
  assign in_ready = w_en;

  // sin(x) = cos(x - quarter turn). The subtraction wraps in ANGLE_W bits.
  // Odd quadrants mirror the index; quadrants 1 and 2 carry a negative sign.
  always_comb begin
    w_angle = (mode_e'(in_sin) == MODE_SIN) ? in_angle - C_QUARTER : in_angle;
    w_quad  = quad_e'(w_angle[ANGLE_W-1 -: 2]);
    w_idx   = w_angle[Q-1:0];
    w_addr  = {1'b0, w_idx};
    w_neg   = 1'b0;
    case (w_quad)
      Q1: begin
        w_addr = C_ADDR_TOP - {1'b0, w_idx};
        w_neg  = 1'b1;
      end
      Q2: w_neg = 1'b1;
      Q3: w_addr = C_ADDR_TOP - {1'b0, w_idx};
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_v1    <= 1'b0;
      r_addr1 <= '0;
      r_neg1  <= 1'b0;
      r_tag1  <= '0;
    end else if (w_en) begin
      r_v1    <= in_valid;
      r_addr1 <= w_addr;
      r_neg1  <= w_neg;
      r_tag1  <= in_tag;
    end
  end

  trig_quarter_rom #(
    .ANGLE_W (ANGLE_W),
    .OUT_W   (OUT_W)
  ) u_rom (
    .Clk  (Clk),
    .en   (w_en),
    .addr (r_addr1),
    .data (w_rom)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_v2   <= 1'b0;
      r_neg2 <= 1'b0;
      r_tag2 <= '0;
    end else if (w_en) begin
      r_v2   <= r_v1;
      r_neg2 <= r_neg1;
      r_tag2 <= r_tag1;
    end
  end

  // |LUT| <= 2^(OUT_W-2), so the negation cannot overflow, and -0 stays 0.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_v3    <= 1'b0;
      r_data3 <= '0;
      r_tag3  <= '0;
    end else if (w_en) begin
      r_v3    <= r_v2;
      r_data3 <= r_neg2 ? -w_rom : w_rom;
      r_tag3  <= r_tag2;
    end
  end

  assign out_valid = r_v3;
  assign out_data  = r_data3;
  assign out_tag   = r_tag3;

endmodule

// File: tb/tb_trig_lut_pipe.sv
// tb_trig_lut_pipe: directed vectors plus a scoreboard for trig_lut_pipe at
// ANGLE_W=10, OUT_W=16, TAG_W=4 (1.0 = 16384).
module tb_trig_lut_pipe;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_angle;
  logic        in_sin;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_tag;

  int n_checks = 0;
  int n_errors = 0;

  int exp_d[$];
  int exp_t[$];

  int v_ang[$];
  int v_sin[$];
  int v_exp[$];

  trig_lut_pipe #(
    .ANGLE_W (10),
    .OUT_W   (16),
    .TAG_W   (4)
  ) u_dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_angle  (in_angle),
    .in_sin    (in_sin),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  always #5 Clk = ~Clk;

  task automatic chk_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int gold(input int ang, input bit s);
    real ph;
    real v;
    ph = 2.0 * 3.14159265358979323846 * real'(ang) / 1024.0;
    v  = 16384.0 * (s ? $sin(ph) : $cos(ph));
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  // Scoreboard: inputs and outputs are stable at the falling edge.
  always @(negedge Clk) begin
    if (!Reset_n) begin
      exp_d.delete();
      exp_t.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_d.size() == 0) begin
          chk_eq("sb_extra", 1, 0);
        end else begin
          chk_eq("sb_data", longint'($signed(out_data)), exp_d.pop_front());
          chk_eq("sb_tag", out_tag, exp_t.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_d.push_back(gold(int'(in_angle), in_sin));
        exp_t.push_back(int'(in_tag));
      end
    end
  end

  task automatic add_vec(input int a, input int s, input int e);
    v_ang.push_back(a);
    v_sin.push_back(s);
    v_exp.push_back(e);
  endtask

  // Back-to-back vectors; sample i is visible after the edge of step i+2.
  task automatic run_dir(input string nm);
    int n;
    n = v_ang.size();
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) begin
        in_valid = 1'b1;
        in_angle = 10'(v_ang[i]);
        in_sin   = v_sin[i][0];
        in_tag   = 4'(i);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge Clk); #1;
      if (i >= 2) begin
        chk_eq({nm, "_valid"}, out_valid, 1);
        chk_eq({nm, "_data"}, longint'($signed(out_data)), v_exp[i-2]);
        chk_eq({nm, "_tag"}, out_tag, (i - 2) % 16);
      end else begin
        chk_eq({nm, "_lat"}, out_valid, 0);
      end
    end
    v_ang.delete();
    v_sin.delete();
    v_exp.delete();
    @(posedge Clk); #1;
  endtask

  initial begin
    int sent;
    int held_d;
    int held_t;
    int cnt;

    Reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_angle  = '0;
    in_sin    = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;

    for (int c = 0; c < 3; c++) begin
      @(posedge Clk); #1;
      chk_eq("rst_valid", out_valid, 0);
      chk_eq("rst_data", out_data, 0);
      chk_eq("rst_tag", out_tag, 0);
    end
    in_valid = 1'b0;
    Reset_n  = 1'b1;
    @(posedge Clk); #1;
    chk_eq("rst_in_ready", in_ready, 1);
    chk_eq("rst_idle", out_valid, 0);

    add_vec(0, 0, 16384);
    add_vec(256, 0, 0);
    add_vec(512, 0, -16384);
    add_vec(768, 0, 0);
    run_dir("cos_card");

    add_vec(256, 1, 16384);
    add_vec(768, 1, -16384);
    add_vec(0, 1, 0);
    add_vec(128, 0, 11585);
    add_vec(384, 0, -11585);
    add_vec(640, 1, -11585);
    run_dir("sin_sym");

    add_vec(1023, 1, -101);
    add_vec(1023, 0, 16384);
    add_vec(1, 1, 101);
    run_dir("wrap");

    // Backpressure: out_ready low on loop cycles 4..7 while 8 samples stream.
    sent   = 0;
    held_d = 0;
    held_t = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 8);
      in_valid  = (sent < 8);
      in_angle  = 10'((sent * 97 + 13) % 1024);
      in_sin    = sent[0];
      in_tag    = 4'(sent + 3);
      #1;
      if (!out_ready) begin
        chk_eq("bp_in_ready", in_ready, 0);
        if (cyc == 4) begin
          chk_eq("bp_stall_valid", out_valid, 1);
          held_d = int'($signed(out_data));
          held_t = int'(out_tag);
        end else begin
          chk_eq("bp_hold_data", longint'($signed(out_data)), held_d);
          chk_eq("bp_hold_tag", out_tag, held_t);
          chk_eq("bp_hold_valid", out_valid, 1);
        end
      end
      if (in_valid && in_ready) sent++;
      if (cyc >= 8 && sent == 8 && exp_d.size() == 0 && !out_valid) break;
      @(posedge Clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk_eq("bp_sent", sent, 8);
    chk_eq("bp_drain", exp_d.size(), 0);
    @(posedge Clk); #1;

    // Full sweep, both modes, compared by the scoreboard.
    for (int j = 0; j < 2048; j++) begin
      in_valid = 1'b1;
      in_angle = 10'(j % 1024);
      in_sin   = (j >= 1024);
      in_tag   = 4'(j % 16);
      @(posedge Clk); #1;
    end
    in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge Clk); #1;
    end
    chk_eq("sweep_drain", exp_d.size(), 0);

    // Reset with three samples in flight.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_angle = 10'(100 * k + 50);
      in_sin   = 1'b0;
      in_tag   = 4'(k + 9);
      @(posedge Clk); #1;
    end
    chk_eq("rst_mid_busy", out_valid, 1);
    Reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    chk_eq("rst_mid_valid", out_valid, 0);
    chk_eq("rst_mid_data", out_data, 0);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge Clk); #1;
      if (out_valid) cnt++;
    end
    chk_eq("rst_flush", cnt, 0);
    chk_eq("rst_in_ready2", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
